keypad_scanner: RTL and testbench

Matrix keypad front end for the digital alarm clock: drives a 4-row × 3-column keypad, synchronizes and debounces the column returns, and presents a 4-bit key code to the alarm controller. A held key shows its digit 0–9, and code 10 (NO_KEY) is shown otherwise. This block is the producer side of the `key` interface that `alarm_controller` consumes. It sits between the board keypad pins and the controller.

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm-clock definitions: key code encoding, keypad scanner states and key map.
package alarm_pkg;

  localparam int unsigned KEY_W = 4;
  localparam logic [KEY_W-1:0] NO_KEY = 4'd10;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_PRESSED  = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_e;

  // Row index plus column pattern to digit; '*', '#', no bits and multiple bits give NO_KEY.
  function automatic logic [KEY_W-1:0] key_map(input logic [1:0] row_idx,
                                               input logic [2:0] col);
    logic [KEY_W-1:0] code;
    code = NO_KEY;
    case ({row_idx, col})
      5'b00_001: code = 4'd1;
      5'b00_010: code = 4'd2;
      5'b00_100: code = 4'd3;
      5'b01_001: code = 4'd4;
      5'b01_010: code = 4'd5;
      5'b01_100: code = 4'd6;
      5'b10_001: code = 4'd7;
      5'b10_010: code = 4'd8;
      5'b10_100: code = 4'd9;
      5'b11_010: code = 4'd0;
      default:   code = NO_KEY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad columns, buttons).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column sync, press/release debounce, key code output.
module keypad_scanner
  import alarm_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       col,
  output logic [3:0]       row,
  output logic [KEY_W-1:0] key,
  output logic             key_strobe
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  // Counter value on which the next stable sample completes the debounce window.
  localparam logic [DW-1:0] DEB_REACH = DW'(DEBOUNCE_CYCLES - 2);

  logic [2:0] col_s;

  kp_state_e        state_q, state_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic [2:0]       pat_q, pat_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             strobe_q, strobe_d;
  logic [KEY_W-1:0] hit_code;
  logic             hit;

  sync_2ff #(.WIDTH(3)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col),
    .q     (col_s)
  );

  assign hit_code = key_map(row_idx_q, col_s);
  assign hit      = (hit_code != NO_KEY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= KP_SCAN;
      row_idx_q <= 2'd0;
      row_q     <= 4'b0001;
      settle_q  <= '0;
      deb_q     <= '0;
      pat_q     <= 3'b000;
      code_q    <= NO_KEY;
      key_q     <= NO_KEY;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      settle_q  <= settle_d;
      deb_q     <= deb_d;
      pat_q     <= pat_d;
      code_q    <= code_d;
      key_q     <= key_d;
      strobe_q  <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    settle_d  = settle_q;
    deb_d     = deb_q;
    pat_d     = pat_q;
    code_d    = code_q;
    key_d     = key_q;
    strobe_d  = 1'b0;

    case (state_q)
      KP_SCAN: begin
        if (settle_q == SETTLE_LAST) begin
          if (hit) begin
            pat_d   = col_s;
            code_d  = hit_code;
            deb_d   = '0;
            state_d = KP_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
            settle_d  = '0;
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      KP_DEBOUNCE: begin
        if (col_s == pat_q) begin
          if (deb_q == DEB_REACH) begin
            key_d    = code_q;
            strobe_d = 1'b1;
            state_d  = KP_PRESSED;
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end else begin
          row_idx_d = row_idx_q + 2'd1;
          settle_d  = '0;
          state_d   = KP_SCAN;
        end
      end

      KP_PRESSED: begin
        if (col_s != pat_q) begin
          deb_d   = '0;
          state_d = KP_RELEASE;
        end
      end

      KP_RELEASE: begin
        // A returning pattern is bounce: resume the hold without a new strobe.
        if (col_s == pat_q) begin
          state_d = KP_PRESSED;
        end else if (deb_q == DEB_REACH) begin
          key_d     = NO_KEY;
          row_idx_d = row_idx_q + 2'd1;
          settle_d  = '0;
          state_d   = KP_SCAN;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end

      default: state_d = KP_SCAN;
    endcase

    row_d = 4'(4'b0001 << row_idx_d);
  end

  assign row        = row_q;
  assign key        = key_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 key matrix on the row/col pins.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_strobe;

  logic [2:0] kmat [4];
  logic       drop;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scanner #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col        (col),
    .row        (row),
    .key        (key),
    .key_strobe (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed switches connect the driven row to their columns; drop models contact bounce.
  always_comb begin
    col = 3'b000;
    for (int r = 0; r < 4; r++) begin
      if (row[r]) col = col | kmat[r];
    end
    if (drop) col = 3'b000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input int max_cyc, output int n, output logic found);
    n = 0;
    found = key_strobe;
    while (!found && n < max_cyc) begin
      @(negedge clk);
      n++;
      found = key_strobe;
    end
  endtask

  task automatic wait_key(input logic [3:0] exp, input int max_cyc, output int n, output int strobes);
    n = 0;
    strobes = 0;
    do begin
      @(negedge clk);
      n++;
      if (key_strobe) strobes++;
    end while (key !== exp && n < max_cyc);
  endtask

  task automatic hold(input int cycles, input logic [3:0] exp, output int strobes, output int bad);
    strobes = 0;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (key_strobe) strobes++;
      if (key !== exp) bad++;
    end
  endtask

  task automatic count_row_changes(input int cycles, output int changes, output int strobes, output int bad);
    logic [3:0] prev;
    changes = 0;
    strobes = 0;
    bad = 0;
    prev = row;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (row !== prev) changes++;
      prev = row;
      if (key_strobe) strobes++;
      if (key !== 4'd10) bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, strobes, bad, changes, first;
    logic found;
    logic [3:0] exp_row;

    reset = 1'b1;
    drop  = 1'b0;
    for (int r = 0; r < 4; r++) kmat[r] = 3'b000;
    do_reset();

    // 1: idle scan, rows rotate every 4 cycles
    check("t1_reset_row", 32'(row), 32'(4'b0001));
    check("t1_reset_key", 32'(key), 32'd10);
    check("t1_reset_strobe", 32'(key_strobe), 32'd0);
    strobes = 0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      exp_row = 4'b0001 << ((k / 4) % 4);
      check("t1_row", 32'(row), 32'(exp_row));
      if (key_strobe) strobes++;
      if (key !== 4'd10) bad++;
      @(negedge clk);
    end
    check("t1_strobes", 32'(strobes), 32'd0);
    check("t1_key_bad", 32'(bad), 32'd0);

    // 2: hold '5', release
    kmat[1] = 3'b010;
    wait_strobe(34, n, found);
    check("t2_strobe_seen", 32'(found), 32'd1);
    check("t2_latency_bound", 32'(n <= 34), 32'd1);
    check("t2_key", 32'(key), 32'd5);
    hold(40, 4'd5, strobes, bad);
    check("t2_hold_strobes", 32'(strobes), 32'd0);
    check("t2_hold_key_bad", 32'(bad), 32'd0);
    kmat[1] = 3'b000;
    wait_key(4'd10, 40, n, strobes);
    check("t2_release_cycles", 32'(n), 32'd18);

    // 3: bouncy '9', then stable, then a short dropout
    kmat[2] = 3'b100;
    strobes = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      drop = 1'b0;
      for (int j = 0; j < 7; j++) begin
        @(negedge clk);
        if (key_strobe) strobes++;
        if (key !== 4'd10) bad++;
      end
      drop = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (key_strobe) strobes++;
        if (key !== 4'd10) bad++;
      end
    end
    check("t3_bounce_strobes", 32'(strobes), 32'd0);
    check("t3_bounce_key_bad", 32'(bad), 32'd0);
    drop = 1'b0;
    wait_strobe(34, n, found);
    check("t3_strobe_seen", 32'(found), 32'd1);
    check("t3_key", 32'(key), 32'd9);
    hold(20, 4'd9, strobes, bad);
    check("t3_hold_strobes", 32'(strobes), 32'd0);
    drop = 1'b1;
    hold(5, 4'd9, strobes, bad);
    first = strobes + bad;
    drop = 1'b0;
    hold(30, 4'd9, strobes, bad);
    check("t3_dropout_strobes", 32'(strobes + first), 32'd0);
    check("t3_dropout_key_bad", 32'(bad), 32'd0);
    kmat[2] = 3'b000;
    wait_key(4'd10, 40, n, strobes);
    check("t3_release_cycles", 32'(n), 32'd18);

    // 4: '*' and '#' are ignored, '0' is accepted
    kmat[3] = 3'b001;
    count_row_changes(40, changes, strobes, bad);
    check("t4_star_row_changes", 32'(changes), 32'd10);
    check("t4_star_strobes", 32'(strobes), 32'd0);
    check("t4_star_key_bad", 32'(bad), 32'd0);
    kmat[3] = 3'b100;
    count_row_changes(40, changes, strobes, bad);
    check("t4_hash_row_changes", 32'(changes), 32'd10);
    check("t4_hash_strobes", 32'(strobes), 32'd0);
    check("t4_hash_key_bad", 32'(bad), 32'd0);
    kmat[3] = 3'b010;
    wait_strobe(34, n, found);
    check("t4_zero_strobe_seen", 32'(found), 32'd1);
    check("t4_zero_key", 32'(key), 32'd0);
    kmat[3] = 3'b000;
    wait_key(4'd10, 40, n, strobes);
    check("t4_zero_release_cycles", 32'(n), 32'd18);

    // 5: '1' held, '3' added, '1' released
    kmat[0] = 3'b001;
    wait_strobe(34, n, found);
    check("t5_one_strobe_seen", 32'(found), 32'd1);
    check("t5_one_key", 32'(key), 32'd1);
    hold(5, 4'd1, strobes, bad);
    kmat[0] = 3'b101;
    wait_key(4'd10, 40, n, strobes);
    check("t5_double_release_cycles", 32'(n), 32'd18);
    check("t5_double_strobes", 32'(strobes), 32'd0);
    hold(10, 4'd10, strobes, bad);
    check("t5_double_idle_strobes", 32'(strobes), 32'd0);
    kmat[0] = 3'b100;
    wait_strobe(34, n, found);
    check("t5_three_strobe_seen", 32'(found), 32'd1);
    check("t5_three_key", 32'(key), 32'd3);
    kmat[0] = 3'b000;
    wait_key(4'd10, 40, n, strobes);
    check("t5_three_release_cycles", 32'(n), 32'd18);

    // 6: exact press latency after reset, then reset mid-DEBOUNCE and mid-PRESSED
    kmat[1] = 3'b010;
    do_reset();
    first = -1;
    for (int k = 0; k < 40; k++) begin
      if (key_strobe && first < 0) begin
        first = k;
        check("t6_key_at_strobe", 32'(key), 32'd5);
      end
      @(negedge clk);
    end
    check("t6_first_strobe_cycle", 32'(first), 32'd23);
    do_reset();
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_deb_reset_row", 32'(row), 32'(4'b0001));
    check("t6_deb_reset_key", 32'(key), 32'd10);
    check("t6_deb_reset_strobe", 32'(key_strobe), 32'd0);
    reset = 1'b0;
    hold(20, 4'd10, strobes, bad);
    check("t6_deb_after_strobes", 32'(strobes), 32'd0);
    wait_strobe(34, n, found);
    check("t6_pressed_strobe_seen", 32'(found), 32'd1);
    hold(5, 4'd5, strobes, bad);
    reset = 1'b1;
    @(negedge clk);
    check("t6_prs_reset_row", 32'(row), 32'(4'b0001));
    check("t6_prs_reset_key", 32'(key), 32'd10);
    check("t6_prs_reset_strobe", 32'(key_strobe), 32'd0);
    reset = 1'b0;
    hold(20, 4'd10, strobes, bad);
    check("t6_prs_after_strobes", 32'(strobes), 32'd0);
    check("t6_prs_after_key_bad", 32'(bad), 32'd0);
    kmat[1] = 3'b000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
